// File: rtl/pipe_skid_reg_pkg.sv
// Shared types and constants for the skid-buffered pipeline stage register.
// The state encoding doubles as the occupancy count, so keep the values fixed.
package pipe_skid_reg_pkg;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   // EMPTY: nothing held, BUSY: main slot full, FULL: main and skid slots full.
   typedef enum logic [1:0] {
      StEmpty = ST_EMPTY,
      StBusy  = ST_BUSY,
      StFull  = ST_FULL
   } state_e;

   // An accepted beat is kept unless empty-beat dropping is on and no lane is valid.
   function automatic logic beat_kept(input logic drop_empty, input logic any_lane);
      return !drop_empty || any_lane;
   endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready beat bus carrying LANES x WIDTH payload plus per-lane valids.
interface pipe_skid_reg_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned LANES = 2
);

   logic                     valid;
   logic                     ready;
   logic [LANES*WIDTH-1:0]   data;
   logic [LANES-1:0]         lane_valid;

   // Producer side of the bus.
   modport master (
      output valid,
      output data,
      output lane_valid,
      input  ready
   );

   // Consumer side of the bus.
   modport slave (
      input  valid,
      input  data,
      input  lane_valid,
      output ready
   );

endinterface

// File: rtl/pipe_skid_reg_slot.sv
// One beat of storage: enable-loaded payload plus lane valids that can be
// cleared synchronously. Payload has no reset; it is qualified by the lane valids
// and by the owning stage's state.
module pipe_skid_reg_slot #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned LANES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clr,
   input  logic                   load,
   input  logic [LANES*WIDTH-1:0] d_data,
   input  logic [LANES-1:0]       d_lane_valid,
   output logic [LANES*WIDTH-1:0] q_data,
   output logic [LANES-1:0]       q_lane_valid
);

   logic [LANES*WIDTH-1:0] data_q;
   logic [LANES-1:0]       lane_valid_q;

   // Payload register: loaded on enable only.
   always_ff @(posedge clk) begin
      if (load) begin
         data_q <= d_data;
      end
   end

   // Lane valids: reset and clear win over a load in the same cycle.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         lane_valid_q <= '0;
      end else if (load) begin
         lane_valid_q <= d_lane_valid;
      end
   end

   assign q_data       = data_q;
   assign q_lane_valid = lane_valid_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a 2-entry skid buffer. in_ready is decoded from
// the state register only, so it never depends combinationally on this cycle's
// inputs. Supports stage flush, dropping of all-lane-invalid beats and a
// saturating count of stalled cycles.
module pipe_skid_reg
   import pipe_skid_reg_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned LANES      = 2,
   parameter bit          DROP_EMPTY = 1'b1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   pipe_skid_reg_if.slave       up,
   pipe_skid_reg_if.master      dn,
   output logic [1:0]           occupancy,
   output logic [CNT_W-1:0]     stall_count
);

   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   state_e state_q, state_d;

   logic in_fire;
   logic out_fire;
   logic store;

   logic main_load;
   logic main_from_skid;
   logic skid_load;

   logic [LANES*WIDTH-1:0] main_d_data;
   logic [LANES-1:0]       main_d_lane_valid;
   logic [LANES*WIDTH-1:0] main_data;
   logic [LANES-1:0]       main_lane_valid;
   logic [LANES*WIDTH-1:0] skid_data;
   logic [LANES-1:0]       skid_lane_valid;

   logic [CNT_W-1:0] stall_q, stall_d;

   // Handshake qualifiers. A dropped beat is still consumed (in_fire) but never stored.
   assign in_fire  = up.valid & up.ready;
   assign out_fire = dn.valid & dn.ready;
   assign store    = in_fire & beat_kept(DROP_EMPTY, |up.lane_valid);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StEmpty;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and slot load enables. Flush overrides every transition and
   // discards an input beat accepted in the same cycle.
   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;

      if (!flush) begin
         unique case (state_q)
            StEmpty: begin
               if (store) begin
                  state_d   = StBusy;
                  main_load = 1'b1;
               end
            end
            StBusy: begin
               if (store && out_fire) begin
                  main_load = 1'b1;
               end else if (store) begin
                  state_d   = StFull;
                  skid_load = 1'b1;
               end else if (out_fire) begin
                  state_d = StEmpty;
               end
            end
            StFull: begin
               // No input is accepted here; only the head can drain.
               if (out_fire) begin
                  state_d        = StBusy;
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
               end
            end
            default: begin
               state_d = StEmpty;
            end
         endcase
      end else begin
         state_d = StEmpty;
      end
   end

   // Main slot refills either from the input bus or from the skid slot.
   always_comb begin
      main_d_data       = up.data;
      main_d_lane_valid = up.lane_valid;
      if (main_from_skid) begin
         main_d_data       = skid_data;
         main_d_lane_valid = skid_lane_valid;
      end
   end

   pipe_skid_reg_slot #(
      .WIDTH (WIDTH),
      .LANES (LANES)
   ) u_main (
      .clk          (clk),
      .reset        (reset),
      .clr          (flush),
      .load         (main_load),
      .d_data       (main_d_data),
      .d_lane_valid (main_d_lane_valid),
      .q_data       (main_data),
      .q_lane_valid (main_lane_valid)
   );

   pipe_skid_reg_slot #(
      .WIDTH (WIDTH),
      .LANES (LANES)
   ) u_skid (
      .clk          (clk),
      .reset        (reset),
      .clr          (flush),
      .load         (skid_load),
      .d_data       (up.data),
      .d_lane_valid (up.lane_valid),
      .q_data       (skid_data),
      .q_lane_valid (skid_lane_valid)
   );

   // Stall counter next value: count head-blocked cycles, hold at all-ones.
   always_comb begin
      stall_d = stall_q;
      if (dn.valid && !dn.ready && !(&stall_q)) begin
         stall_d = stall_q + CntOne;
      end
   end

   // Stall counter register; flush deliberately leaves it alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign up.ready      = (state_q != StFull);
   assign dn.valid      = (state_q != StEmpty);
   assign dn.data       = main_data;
   assign dn.lane_valid = main_lane_valid & {LANES{dn.valid}};
   assign occupancy     = state_q;
   assign stall_count   = stall_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomized bench for pipe_skid_reg. The reference model is a FIFO of at most
// two beats; the driver pushes each beat it expects to be stored, the monitor
// compares handshake/status outputs every cycle and pops on each output transfer.
module tb_pipe_skid_reg;

   localparam int unsigned WIDTH      = 32;
   localparam int unsigned LANES      = 2;
   localparam bit          DROP_EMPTY = 1'b1;
   localparam int unsigned CNT_W      = 3;
   localparam int          CNT_MAX    = (1 << CNT_W) - 1;

   typedef struct packed {
      logic [LANES*WIDTH-1:0] data;
      logic [LANES-1:0]       lanes;
   } beat_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush;
   logic [1:0]       occupancy;
   logic [CNT_W-1:0] stall_count;

   pipe_skid_reg_if #(.WIDTH(WIDTH), .LANES(LANES)) up ();
   pipe_skid_reg_if #(.WIDTH(WIDTH), .LANES(LANES)) dn ();

   pipe_skid_reg #(
      .WIDTH      (WIDTH),
      .LANES      (LANES),
      .DROP_EMPTY (DROP_EMPTY),
      .CNT_W      (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .up          (up),
      .dn          (dn),
      .occupancy   (occupancy),
      .stall_count (stall_count)
   );

   always #5 clk = ~clk;

   beat_t exp_q[$];
   int    m_occ    = 0;
   int    m_cnt    = 0;
   bit    pushed   = 1'b0;
   bit    started  = 1'b0;
   int    n_checks = 0;
   int    n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus; probabilities in percent.
   task automatic drive(input int pv, input int pr, input int pz, input int pf, input int prs);
      beat_t b;
      reset       = ($urandom_range(99, 0) < prs);
      flush       = ($urandom_range(99, 0) < pf);
      up.valid    = ($urandom_range(99, 0) < pv);
      up.data     = {$urandom(), $urandom()};
      up.lane_valid = ($urandom_range(99, 0) < pz) ? 2'b00 : 2'($urandom_range(3, 1));
      dn.ready    = ($urandom_range(99, 0) < pr);
      pushed = up.valid && (m_occ < 2) && !reset && !flush &&
               (!DROP_EMPTY || (up.lane_valid != '0));
      if (pushed) begin
         b.data  = up.data;
         b.lanes = up.lane_valid;
         exp_q.push_back(b);
      end
   endtask

   // Stimulus: initial reset with input valid held, then phases of differing traffic.
   initial begin
      reset         = 1'b1;
      flush         = 1'b0;
      up.valid      = 1'b1;
      up.data       = 64'hdead_beef_0123_4567;
      up.lane_valid = 2'b11;
      dn.ready      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      started = 1'b1;
      for (int p = 0; p < 6; p++) begin
         for (int c = 0; c < 400; c++) begin
            unique case (p)
               0: drive(100, 100, 0, 0, 0);
               1: drive(85, 20, 0, 0, 0);
               2: drive(60, 60, 30, 0, 0);
               3: drive(90, 50, 5, 8, 0);
               4: drive(70, 50, 10, 3, 3);
               default: drive(50, 0, 0, 0, 0);
            endcase
            @(posedge clk);
            #1;
         end
      end
      // Drain what is left.
      for (int c = 0; c < 6; c++) begin
         drive(0, 100, 0, 0, 0);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Monitor: compare at the falling edge, then advance the model across the next rise.
   initial begin
      beat_t h;
      bit    popped;
      wait (started);
      forever begin
         @(negedge clk);
         popped = 1'b0;
         check("in_ready", 64'(up.ready), 64'(m_occ < 2));
         check("out_valid", 64'(dn.valid), 64'(m_occ > 0));
         check("occupancy", 64'(occupancy), 64'(m_occ));
         check("stall_count", 64'(stall_count), 64'(m_cnt));
         if (m_occ == 0) begin
            check("idle_lane_valid", 64'(dn.lane_valid), 64'(0));
         end else if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 64'(exp_q.size()), 64'(m_occ));
         end else if (dn.ready) begin
            h = exp_q.pop_front();
            popped = 1'b1;
            check("out_data", dn.data, h.data);
            check("out_lane_valid", 64'(dn.lane_valid), 64'(h.lanes));
         end else begin
            check("stalled_lane_valid", 64'(dn.lane_valid), 64'(exp_q[0].lanes));
            check("stalled_data", dn.data, exp_q[0].data);
         end

         if (reset) begin
            exp_q.delete();
            m_occ = 0;
            m_cnt = 0;
         end else begin
            if (m_occ > 0 && !dn.ready && m_cnt < CNT_MAX) m_cnt++;
            if (flush) begin
               exp_q.delete();
               m_occ = 0;
            end else begin
               m_occ = m_occ - int'(popped) + int'(pushed);
            end
         end
      end
   end

endmodule
